// File: rtl/io_port_unit_pkg.sv
// Shared definitions for the IO port unit: FSM state encoding and default widths.
package io_port_unit_pkg;

    // Width of the register bus feeding the CPU data path.
    localparam int REG_DW = 32;

    // Default debounce hold time in cycles; roughly 10 ms at 100 MHz.
    localparam int DB_CNT_DEFAULT = 1000000;

    // IN-instruction handshake states.
    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_PRESS = 2'd1,
        ACK        = 2'd2
    } io_state_t;

endpackage

// File: rtl/io_port_unit_if.sv
// CPU-side IO bus: read/write qualifiers, data in both directions and the IN-complete pulse.
interface io_port_unit_if
    import io_port_unit_pkg::*;
#(
    parameter int DW = REG_DW
);
    logic          io_re_i;
    logic          io_we_i;
    logic [DW-1:0] cpu_data_i;
    logic [DW-1:0] cpu_data_o;
    logic          enter_o;

    // Core side drives the qualifiers and write data.
    modport master (
        output io_re_i,
        output io_we_i,
        output cpu_data_i,
        input  cpu_data_o,
        input  enter_o
    );

    // Peripheral side answers with read data and the completion pulse.
    modport slave (
        input  io_re_i,
        input  io_we_i,
        input  cpu_data_i,
        output cpu_data_o,
        output enter_o
    );
endinterface

// File: rtl/io_port_unit_btn_debounce.sv
// Button front end: 2-flop synchronizer, hold-time debouncer and rising-edge detector.
module btn_debounce
    import io_port_unit_pkg::*;
#(
    parameter int DB_CNT = DB_CNT_DEFAULT,
    parameter int DB_W   = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic level,
    output logic press
);
    logic            sync1;
    logic            sync2;
    logic            level_q;
    logic [DB_W-1:0] cnt;

    // Synchronize the raw button into the clock domain.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
        end
    end

    // Accept a new level only after it has differed for DB_CNT consecutive cycles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt     <= '0;
            level   <= 1'b0;
            level_q <= 1'b0;
        end else begin
            level_q <= level;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == DB_W'(DB_CNT - 1)) begin
                level <= sync2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign press = level & ~level_q;

endmodule

// File: rtl/io_port_unit.sv
// IO port responder: OUT latches write data onto the LEDs, IN waits for a debounced
// press, captures the switches and pulses enter_o to release the core's stall.
module io_port_unit
    import io_port_unit_pkg::*;
#(
    parameter int DW       = REG_DW,
    parameter int SW_W     = 16,
    parameter int SIGN_EXT = 0,
    parameter int DB_CNT   = DB_CNT_DEFAULT,
    parameter int DB_W     = 20
) (
    input  logic                clk,
    input  logic                rst,
    io_port_unit_if.slave       cpu,
    input  logic                btn_i,
    input  logic [SW_W-1:0]     sw_i,
    output logic [DW-1:0]       led_o,
    output logic                wait_o
);
    io_state_t     state;
    io_state_t     state_nxt;
    logic          press;
    logic          btn_level;
    logic          capture;
    logic [DW-1:0] sw_ext;

    btn_debounce #(
        .DB_CNT (DB_CNT),
        .DB_W   (DB_W)
    ) u_btn (
        .clk   (clk),
        .rst   (rst),
        .btn   (btn_i),
        .level (btn_level),
        .press (press)
    );

    // Widen the switch bank to the data width, filling from the MSB or with zeros.
    always_comb begin
        sw_ext             = (SIGN_EXT != 0 && sw_i[SW_W-1]) ? '1 : '0;
        sw_ext[SW_W-1:0]   = sw_i;
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // Next state; a press outranks a dropped io_re_i while waiting.
    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        unique case (state)
            IDLE:       if (cpu.io_re_i) state_nxt = WAIT_PRESS;
            WAIT_PRESS: begin
                if (press) begin
                    capture   = 1'b1;
                    state_nxt = ACK;
                end else if (!cpu.io_re_i) begin
                    state_nxt = IDLE;
                end
            end
            ACK:        state_nxt = IDLE;
            default:    state_nxt = IDLE;
        endcase
    end

    // Read capture register holds the last switch sample until the next IN completes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)         cpu.cpu_data_o <= '0;
        else if (capture) cpu.cpu_data_o <= sw_ext;
    end

    // LED register written by OUT regardless of the IN handshake.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)              led_o <= '0;
        else if (cpu.io_we_i)  led_o <= cpu.cpu_data_i;
    end

    assign cpu.enter_o = (state == ACK);
    assign wait_o      = (state == WAIT_PRESS);

endmodule

// File: tb/tb_io_port_unit.sv
// Self-checking bench: zero- and sign-extending instances driven in lock-step against
// a cycle-level reference model, with directed scenarios followed by random traffic.
module tb_io_port_unit;
    localparam int DB_CNT = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        btn = 1'b0;
    logic [15:0] sw  = '0;
    logic        re  = 1'b0;
    logic        we  = 1'b0;
    logic [31:0] din = '0;

    logic [31:0] led0, led1;
    logic        wait0, wait1;

    int checks = 0;
    int errors = 0;

    io_port_unit_if #(.DW(32)) bus0 ();
    io_port_unit_if #(.DW(32)) bus1 ();

    assign bus0.io_re_i = re;    assign bus1.io_re_i = re;
    assign bus0.io_we_i = we;    assign bus1.io_we_i = we;
    assign bus0.cpu_data_i = din; assign bus1.cpu_data_i = din;

    io_port_unit #(.DW(32), .SW_W(16), .SIGN_EXT(0), .DB_CNT(DB_CNT), .DB_W(3)) dut0 (
        .clk(clk), .rst(rst), .cpu(bus0), .btn_i(btn), .sw_i(sw), .led_o(led0), .wait_o(wait0)
    );
    io_port_unit #(.DW(32), .SW_W(16), .SIGN_EXT(1), .DB_CNT(DB_CNT), .DB_W(3)) dut1 (
        .clk(clk), .rst(rst), .cpu(bus1), .btn_i(btn), .sw_i(sw), .led_o(led1), .wait_o(wait1)
    );

    always #5 clk = ~clk;

    // Reference model: button seen after two cycles, accepted after DB_CNT cycles of
    // disagreement; an IN is a pending request served by the first press while pending.
    logic        m_b1, m_b2, m_db, m_dbp;
    int          m_run;
    logic        m_waiting, m_acking;
    logic [15:0] m_sw;
    logic [31:0] m_led;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_b1 = 0; m_b2 = 0; m_db = 0; m_dbp = 0; m_run = 0;
        m_waiting = 0; m_acking = 0; m_sw = '0; m_led = '0;
    endtask

    task automatic model_step();
        logic pressed;
        logic old_db;
        if (!rst) begin
            model_reset();
            return;
        end
        pressed = m_db && !m_dbp;
        if (we) m_led = din;
        if (m_acking) begin
            m_acking = 0;
        end else if (m_waiting) begin
            if (pressed) begin
                m_sw = sw; m_waiting = 0; m_acking = 1;
            end else if (!re) begin
                m_waiting = 0;
            end
        end else if (re) begin
            m_waiting = 1;
        end
        old_db = m_db;
        if (m_b2 == m_db) m_run = 0;
        else if (m_run == DB_CNT - 1) begin m_db = m_b2; m_run = 0; end
        else m_run++;
        m_dbp = old_db;
        m_b2  = m_b1;
        m_b1  = btn;
    endtask

    task automatic check_all();
        check("led0",   led0, m_led);
        check("led1",   led1, m_led);
        check("wait0",  32'(wait0), 32'(m_waiting));
        check("wait1",  32'(wait1), 32'(m_waiting));
        check("enter0", 32'(bus0.enter_o), 32'(m_acking));
        check("enter1", 32'(bus1.enter_o), 32'(m_acking));
        check("rdata0", bus0.cpu_data_o, {16'h0, m_sw});
        check("rdata1", bus1.cpu_data_o, {{16{m_sw[15]}}, m_sw});
    endtask

    // One clock: model follows the edge, outputs compared on the falling edge.
    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            model_step();
            @(negedge clk);
            check_all();
        end
    endtask

    int n_enter;
    int lat;
    int btn_left;
    int re_left;

    initial begin
        model_reset();
        tick(3);
        rst = 1'b1;
        tick(1);

        // OUT path
        we = 1; din = 32'hDEADBEEF;
        tick(1);
        we = 0; din = '0;
        check("led_out", led0, 32'hDEADBEEF);
        tick(2);

        // IN with zero-extended capture and latency from the button rise
        re = 1; sw = 16'h1234; btn = 1;
        lat = 0;
        while (lat < 20 && !bus0.enter_o) begin
            tick(1);
            lat++;
        end
        check("in_latency", 32'(lat), 32'd7);
        check("in_data0", bus0.cpu_data_o, 32'h00001234);
        re = 0;
        tick(1);
        check("enter_one_cycle", 32'(bus0.enter_o), 32'd0);
        btn = 0;
        tick(10);

        // Sign-extended capture
        re = 1; sw = 16'h8001; btn = 1;
        lat = 0;
        while (lat < 20 && !bus1.enter_o) begin
            tick(1);
            lat++;
        end
        check("sext_data1", bus1.cpu_data_o, 32'hFFFF8001);
        check("zext_data0", bus0.cpu_data_o, 32'h00008001);

        // Held button across a second IN: no completion until release and re-press
        n_enter = 0;
        for (int i = 0; i < 15; i++) begin
            tick(1);
            if (bus0.enter_o) n_enter++;
        end
        check("held_no_second", 32'(n_enter), 32'd0);
        btn = 0; tick(8); btn = 1;
        for (int i = 0; i < 12; i++) begin
            tick(1);
            if (bus0.enter_o) n_enter++;
        end
        check("repress_one", 32'(n_enter), 32'd1);
        re = 0; btn = 0; tick(10);

        // Press while idle is not buffered
        btn = 1; tick(10);
        re = 1; n_enter = 0;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            if (bus0.enter_o) n_enter++;
        end
        check("idle_press_dropped", 32'(n_enter), 32'd0);

        // Flush while waiting
        re = 0; tick(1);
        check("flush_wait", 32'(wait0), 32'd0);
        btn = 0; tick(10);

        // Bouncing button then stable: exactly one completion
        re = 1; n_enter = 0;
        for (int i = 0; i < 20; i++) begin
            btn = (i % 4) < 2;
            tick(1);
            if (bus0.enter_o) n_enter++;
        end
        check("bounce_no_enter", 32'(n_enter), 32'd0);
        btn = 1;
        for (int i = 0; i < 12; i++) begin
            tick(1);
            if (bus0.enter_o) n_enter++;
            if (bus0.enter_o) re = 0;
        end
        check("bounce_one_enter", 32'(n_enter), 32'd1);
        btn = 0; tick(10);

        // Reset asserted during ACK
        re = 1; btn = 1; sw = 16'hBEEF;
        lat = 0;
        while (lat < 20 && !bus0.enter_o) begin
            tick(1);
            lat++;
        end
        check("ack_reached", 32'(bus0.enter_o), 32'd1);
        rst = 0;
        #1;
        check("rst_enter", 32'(bus0.enter_o), 32'd0);
        check("rst_rdata", bus0.cpu_data_o, 32'd0);
        check("rst_led", led0, 32'd0);
        model_reset();
        re = 0; btn = 0;
        tick(2);
        rst = 1;
        tick(2);

        // Random traffic
        btn_left = 0; re_left = 0;
        for (int i = 0; i < 1500; i++) begin
            if (btn_left == 0) begin
                btn = ~btn;
                btn_left = ($urandom_range(0, 3) == 0) ? $urandom_range(8, 20) : $urandom_range(1, 5);
            end
            btn_left--;
            if (re_left == 0) begin
                re = ($urandom_range(0, 3) != 0);
                re_left = $urandom_range(1, 30);
            end
            re_left--;
            we  = ($urandom_range(0, 3) == 0);
            din = $urandom;
            sw  = 16'($urandom);
            tick(1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/io_port_unit.md
Name: io_port_unit

Overview:
- Peripheral-side responder for the CPU core's IO interface: the core's `io_re` / `io_we`, `data_o`, `data_i` and `enter` signals.
- OUT instruction: latches the core's write data into an output register that drives the board LEDs.
- IN instruction: waits for a debounced operator button press, then captures the switch inputs, presents them to the core, and pulses `enter_o` for one cycle to release the core's memory-stage stall.
- Sits at board top level, between the CPU core and the physical switches, button and LEDs.

Parameters:
- DW, 32, CPU data width.
- SW_W, 16, width of the switch input bus (SW_W ≤ DW).
- SIGN_EXT, 0, 1 = sign-extend switch value to DW, 0 = zero-extend.
- DB_CNT, 1000000, cycles the synchronized button must hold a new level before it is accepted.
- DB_W, 20, counter width; must satisfy 2^DB_W ≥ DB_CNT.

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  asynchronous, active-low reset.
- io_re_i  in  1  core memory stage is executing IN (level, held while stalled).
- io_we_i  in  1  core memory stage is executing OUT (one-cycle qualifier).
- cpu_data_i  in  DW  write data from the core.
- cpu_data_o  out  DW  read data to the core.
- enter_o  out  1  one-cycle IN-complete pulse to the core's stall controller.
- btn_i  in  1  raw, asynchronous operator button, active-high.
- sw_i  in  SW_W  raw switch bank, quasi-static.
- led_o  out  DW  output register.
- wait_o  out  1  high while an IN is waiting for the operator (indicator LED).

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; cpu_data_o=0; led_o=0; enter_o=0; wait_o=0; sync flops=0; debounced level=0; counter=0.
- Button path: 2-flop synchronizer on btn_i, then debouncer.
  - Counter clears whenever the synced level equals the debounced level; otherwise it increments.
  - When the counter reaches DB_CNT-1, the debounced level takes the synced level and the counter clears.
  - `press` = one-cycle rising edge of the debounced level.
  - Latency from a clean btn_i rise to `press` = 2 + DB_CNT cycles.
- OUT path: on a clk edge with io_we_i=1, led_o <= cpu_data_i. Independent of FSM state; serviced in zero stall cycles.
- FSM states: IDLE, WAIT_PRESS, ACK.
  - IDLE: if io_re_i=1, go to WAIT_PRESS next cycle. A `press` seen in IDLE is discarded (no buffering).
  - WAIT_PRESS: wait_o=1.
    - `press`=1: cpu_data_o <= extend(sw_i sampled at this edge); go to ACK.
    - io_re_i=0 (pipeline flush or reset of core): go to IDLE with no capture and no enter_o.
    - `press` has priority if both occur in the same cycle.
  - ACK: enter_o=1 for exactly this cycle; cpu_data_o is valid and stable throughout it. Always return to IDLE.
- cpu_data_o holds its last captured value until the next capture; the core samples it in the ACK cycle.
- A held button yields exactly one `press`. A second IN requires release (debounced low) and a new press.
- A `press` can never coincide with IDLE→WAIT_PRESS entry in a way that serves the new IN, because the press is consumed only in WAIT_PRESS.
- Simultaneous io_we_i and io_re_i: both are serviced; the write is unaffected by FSM state.
- Extension: SIGN_EXT=1 replicates sw_i[SW_W-1] into the upper bits; SIGN_EXT=0 fills the upper bits with 0.
- rst asserted mid-operation, including in ACK: outputs return to reset values immediately; enter_o drops without completing.

Decomposition:
- Shared package / defines: IO FSM state encodings (2-bit), DB_CNT default, DW tied to the existing register-bus width define.
- Sub-module btn_debounce (synchronizer + counter + edge detect; outputs level and press). It is natural to reuse for any future front-panel buttons.
- All remaining logic (FSM, read capture register, LED register) lives in io_port_unit.

Test Plan (sim with DB_CNT=4, DB_W=3, SW_W=16):
1. Reset, then io_we_i=1 for one cycle with cpu_data_i=32'hDEADBEEF → led_o=32'hDEADBEEF the next cycle; enter_o stays 0.
2. io_re_i held, sw_i=16'h1234, clean btn_i press → wait_o=1 until the press; enter_o pulses exactly 1 cycle, 6 cycles after btn_i rise plus 1; cpu_data_o=32'h00001234 in that cycle.
3. SIGN_EXT=1, sw_i=16'h8001 → cpu_data_o=32'hFFFF8001 during ACK.
4. btn_i bouncing 1/0 every 2 cycles for 20 cycles, then stable 1 → exactly one enter_o pulse, only after the stable period.
5. Button held high across two back-to-back IN operations → only the first completes; the second completes only after release and re-press. Also: a press in IDLE followed by io_re_i → no enter_o.
6. io_re_i deasserted in WAIT_PRESS → return to IDLE with no enter_o. Separately, rst asserted during ACK → enter_o=0 and cpu_data_o=0 immediately.
